// File: rtl/pos_profile_sequencer_pkg.sv
// Shared state/status codes, command bundle and helpers
// for the single-axis point-to-point profile sequencer.
package pos_profile_sequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEL  = 3'd1;
  localparam logic [2:0] ST_CRUISE = 3'd2;
  localparam logic [2:0] ST_DECEL  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_ABORT   = 2'b01;
  localparam logic [1:0] STS_TIMEOUT = 2'b10;
  localparam logic [1:0] STS_BADCMD  = 2'b11;

  localparam int DIVIDER_DEF = 5000;

  typedef struct packed {
    logic signed [31:0] target;
    logic [15:0]        vmax;
    logic [15:0]        accel;
  } move_cmd_t;

  // |a-b| without overflow: 33-bit signed diff, unsigned result
  function automatic logic [32:0] abs_diff(
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    logic signed [32:0] d;
    d = {a[31], a} - {b[31], b};
    return d[32] ? (~d + 33'd1) : d;
  endfunction

endpackage

// File: rtl/pos_profile_sequencer_if.sv
// Move command handshake between a host and one
// axis sequencer: valid/ready plus the command fields.
interface pos_profile_sequencer_if;

  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [31:0] cmd_target;
  logic [15:0]        cmd_vmax;
  logic [15:0]        cmd_accel;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_vmax,
    output cmd_accel,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_vmax,
    input  cmd_accel,
    output cmd_ready
  );

endinterface

// File: rtl/ctrl_tick_gen.sv
// Control-rate tick: one-clk pulse every DIVIDER clocks,
// first pulse on the first clock after reset release.
module ctrl_tick_gen #(
  parameter int DIVIDER = 5000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [CW-1:0] cnt;

  // Free-running divider, wraps at DIVIDER-1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CW'(DIVIDER - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/pos_profile_sequencer.sv
// Trapezoid/triangle setpoint sequencer with settle
// supervision; drives desired_pos of one PID axis.
module pos_profile_sequencer
  import pos_profile_sequencer_pkg::*;
#(
  parameter int DIVIDER        = DIVIDER_DEF,
  parameter int INPOS_WIN      = 100,
  parameter int SETTLE_TICKS   = 20,
  parameter int SETTLE_TIMEOUT = 20000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pos_profile_sequencer_if.slave cmd,
  input  logic                   abort,
  input  logic signed [31:0]     actual_pos,
  output logic signed [31:0]     desired_pos,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             status,
  output logic [2:0]             phase
);

  localparam int WCW = $clog2(SETTLE_TICKS + 1);
  localparam int TCW = $clog2(SETTLE_TIMEOUT + 1);

  logic               tick;
  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [2:0]         mv_n;
  move_cmd_t          cq;
  logic signed [31:0] pos_cmd;
  logic signed [31:0] pos_nx;
  logic signed [31:0] step_s;
  logic [15:0]        vel;
  logic [15:0]        v_n;
  logic [15:0]        v_up;
  logic [15:0]        v_dn;
  logic [15:0]        step;
  logic [16:0]        vel_sum;
  logic [31:0]        ramp_dist;
  logic [31:0]        ramp_n;
  logic [31:0]        ramp_sat;
  logic [32:0]        ramp_sum;
  logic [32:0]        cruise_lim;
  logic [32:0]        rem;
  logic [32:0]        perr;
  logic               dir;
  logic [WCW-1:0]     win_cnt;
  logic [WCW-1:0]     win_n;
  logic [WCW-1:0]     win_d;
  logic [TCW-1:0]     tmo_cnt;
  logic [TCW-1:0]     tmo_n;
  logic [TCW-1:0]     tmo_d;
  logic               inwin;
  logic               cmd_bad;
  logic               done_n;
  logic [1:0]         status_n;

  ctrl_tick_gen #(
    .DIVIDER(DIVIDER)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign phase         = state;
  assign cmd_bad       = (cmd.cmd_vmax == '0) ||
                         (cmd.cmd_accel == '0);

  // Next velocity/step for one control tick
  always_comb begin
    rem        = abs_diff(cq.target, pos_cmd);
    vel_sum    = {1'b0, vel} + {1'b0, cq.accel};
    v_up       = (vel_sum >= {1'b0, cq.vmax}) ?
                 cq.vmax : vel_sum[15:0];
    v_dn       = (vel > cq.accel) ?
                 vel - cq.accel : 16'd1;
    ramp_sum   = {1'b0, ramp_dist} + {17'd0, v_up};
    ramp_sat   = ramp_sum[32] ? '1 : ramp_sum[31:0];
    cruise_lim = {1'b0, ramp_dist} + {17'd0, cq.vmax};
    v_n        = vel;
    mv_n       = state;
    ramp_n     = ramp_dist;
    case (state)
      ST_ACCEL: begin
        // braking starts on the very tick distance runs out
        if (rem <= {1'b0, ramp_dist}) begin
          v_n  = v_dn;
          mv_n = ST_DECEL;
        end else begin
          v_n    = v_up;
          ramp_n = ramp_sat;
          if (v_up == cq.vmax) mv_n = ST_CRUISE;
        end
      end
      ST_CRUISE: begin
        v_n = cq.vmax;
        if (rem <= cruise_lim) mv_n = ST_DECEL;
      end
      ST_DECEL: v_n = v_dn;
      default: ;
    endcase
    step   = ({17'd0, v_n} < rem) ? v_n : rem[15:0];
    step_s = $signed({16'd0, step});
    pos_nx = dir ? pos_cmd - step_s : pos_cmd + step_s;
  end

  // In-position window and settle counters
  always_comb begin
    perr  = abs_diff(cq.target, actual_pos);
    inwin = (perr <= 33'(INPOS_WIN));
    win_n = inwin ? win_cnt + WCW'(1) : '0;
    tmo_n = tmo_cnt + TCW'(1);
  end

  // FSM next-state, completion pulse and status
  always_comb begin
    state_n  = state;
    done_n   = 1'b0;
    status_n = status;
    win_d    = win_cnt;
    tmo_d    = tmo_cnt;
    if (state == ST_IDLE) begin
      if (cmd.cmd_valid) begin
        win_d = '0;
        tmo_d = '0;
        if (cmd_bad) begin
          done_n   = 1'b1;
          status_n = STS_BADCMD;
        end else if (cmd.cmd_target == pos_cmd) begin
          state_n = ST_SETTLE;
        end else begin
          state_n = ST_ACCEL;
        end
      end
    end else if (abort) begin
      state_n  = ST_IDLE;
      done_n   = 1'b1;
      status_n = STS_ABORT;
    end else if (tick) begin
      if (state == ST_SETTLE) begin
        win_d = win_n;
        tmo_d = tmo_n;
        if (win_n == WCW'(SETTLE_TICKS)) begin
          state_n  = ST_IDLE;
          done_n   = 1'b1;
          status_n = STS_OK;
        end else if (tmo_n == TCW'(SETTLE_TIMEOUT)) begin
          state_n  = ST_IDLE;
          done_n   = 1'b1;
          status_n = STS_TIMEOUT;
        end
      end else if (rem == '0) begin
        state_n = ST_SETTLE;
      end else begin
        state_n = mv_n;
      end
    end
  end

  // FSM state and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      status  <= STS_OK;
      win_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      done    <= done_n;
      status  <= status_n;
      win_cnt <= win_d;
      tmo_cnt <= tmo_d;
    end
  end

  // Profile datapath: command latch, position and velocity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cq          <= '0;
      pos_cmd     <= '0;
      vel         <= '0;
      ramp_dist   <= '0;
      dir         <= 1'b0;
      desired_pos <= '0;
    end else begin
      desired_pos <= (state == ST_SETTLE) ?
                     cq.target : pos_cmd;
      if (state == ST_IDLE) begin
        if (cmd.cmd_valid) begin
          cq.target <= cmd.cmd_target;
          cq.vmax   <= cmd.cmd_vmax;
          cq.accel  <= cmd.cmd_accel;
          vel       <= '0;
          ramp_dist <= '0;
          dir       <= ($signed(cmd.cmd_target) < pos_cmd);
        end
      end else if (abort) begin
        vel <= '0;
      end else if (tick && state != ST_SETTLE) begin
        if (rem == '0) begin
          vel <= '0;
        end else begin
          pos_cmd   <= pos_nx;
          vel       <= v_n;
          ramp_dist <= ramp_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_pos_profile_sequencer.sv
// Scoreboard bench for pos_profile_sequencer: a move
// planner predicts setpoints and completion events.
module tb_pos_profile_sequencer;

  localparam int D   = 4;
  localparam int WIN = 100;
  localparam int ST  = 20;
  localparam int TMO = 50;

  typedef struct {
    logic [1:0] st;
    longint     pos;
    int         at;
  } done_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               abort = 1'b0;
  logic               track = 1'b1;
  logic signed [31:0] hold_pos = '0;
  logic signed [31:0] actual_pos;
  logic signed [31:0] desired_pos;
  logic               busy;
  logic               done;
  logic [1:0]         status;
  logic [2:0]         phase;

  pos_profile_sequencer_if bus ();

  pos_profile_sequencer #(
    .DIVIDER       (D),
    .INPOS_WIN     (WIN),
    .SETTLE_TICKS  (ST),
    .SETTLE_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (bus),
    .abort      (abort),
    .actual_pos (actual_pos),
    .desired_pos(desired_pos),
    .busy       (busy),
    .done       (done),
    .status     (status),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  assign actual_pos = track ? desired_pos : hold_pos;

  int     cyc = -1;
  int     checks = 0;
  int     errors = 0;
  bit     mon_on = 1'b0;
  longint model_pos = 0;
  longint last_dp = 0;
  longint exp_pos[$];
  done_t  exp_done[$];

  always @(posedge clk) begin
    if (!reset_n) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  // Reference planner: walks the move tick by tick using
  // plain arithmetic and queues each new setpoint.
  function automatic int plan_move(input longint tgt,
                                   input int vm,
                                   input int ac,
                                   input int kmax);
    longint r, step, built;
    int     v, vn, n;
    bit     cruising, braking;
    built = 0; v = 0; n = 0;
    cruising = 0; braking = 0;
    while (n < kmax) begin
      r = tgt - model_pos;
      if (r < 0) r = -r;
      n++;
      if (r == 0) return n;
      if (braking) begin
        vn = (v > ac) ? v - ac : 1;
      end else if (cruising) begin
        vn = vm;
        braking = (r <= built + vm);
      end else if (r <= built) begin
        braking = 1;
        vn = (v > ac) ? v - ac : 1;
      end else begin
        vn = (v + ac < vm) ? v + ac : vm;
        built += vn;
        cruising = (vn == vm);
      end
      step = (vn < r) ? vn : r;
      model_pos += (tgt > model_pos) ? step : -step;
      v = vn;
      exp_pos.push_back(model_pos);
    end
    return n;
  endfunction

  // Monitor: setpoint trajectory and completion events
  always @(negedge clk) begin
    done_t e;
    if (reset_n && mon_on) begin
      if (desired_pos != last_dp) begin
        if (exp_pos.size() == 0)
          chk("traj_extra", desired_pos, last_dp);
        else
          chk("traj", desired_pos, exp_pos.pop_front());
        last_dp = desired_pos;
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("done_extra", done, 0);
        end else begin
          e = exp_done.pop_front();
          chk("status", status, e.st);
          chk("done_pos", desired_pos, e.pos);
          chk("done_cycle", cyc, e.at);
          chk("traj_left", exp_pos.size(), 0);
        end
      end
    end
  end

  task automatic issue(input longint tgt,
                       input int vm,
                       input int ac,
                       input int kab,
                       input bit tmo,
                       input bit poke);
    int    a, t1, m, guard;
    done_t e;
    do @(negedge clk); while (cyc % D != 0);
    a  = cyc + 1;
    t1 = a + D - 1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 32'(tgt);
    bus.cmd_vmax   = 16'(vm);
    bus.cmd_accel  = 16'(ac);
    if (vm == 0 || ac == 0) begin
      e.st = 2'b11; e.pos = model_pos; e.at = a;
    end else begin
      m = (tgt == model_pos) ? 0 :
          plan_move(tgt, vm, ac, (kab > 0) ? kab : 1000000);
      if (kab > 0) begin
        e.st = 2'b01; e.pos = model_pos;
        e.at = t1 + kab * D;
      end else begin
        e.st  = tmo ? 2'b10 : 2'b00;
        e.pos = tgt;
        e.at  = t1 + (m + (tmo ? TMO : ST) - 1) * D;
      end
    end
    exp_done.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (poke) begin
      repeat (2 * D) @(negedge clk);
      chk("ready_busy", bus.cmd_ready, 0);
      chk("busy_flag", busy, 1);
      bus.cmd_valid  = 1'b1;
      bus.cmd_target = -32'sd5000;
      bus.cmd_vmax   = 16'd7;
      bus.cmd_accel  = 16'd3;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    if (kab > 0) begin
      // raised so the abort clk is also a tick clk
      while (cyc < t1 + kab * D - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    guard = 0;
    while (exp_done.size() != 0 && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_done.size() != 0) begin
      chk("done_wait", exp_done.size(), 0);
      exp_done.delete();
      exp_pos.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = '0;
    bus.cmd_vmax   = '0;
    bus.cmd_accel  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_desired", desired_pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_status", status, 0);
    chk("rst_done", done, 0);
    chk("rst_phase", phase, 0);
    mon_on = 1'b1;

    issue(1000, 50, 5, 0, 0, 1);
    issue(0, 50, 5, 0, 0, 0);
    issue(-100, 1000, 10, 0, 0, 0);
    issue(100000, 200, 4, 60, 0, 0);
    issue(0, 200, 4, 0, 0, 0);

    track = 1'b0;
    hold_pos = '0;
    issue(500, 100, 10, 0, 1, 0);
    track = 1'b1;

    abort = 1'b1;
    issue(700, 50, 0, 0, 0, 0);
    abort = 1'b0;
    issue(700, 0, 9, 0, 0, 0);
    issue(500, 30, 3, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int     r;
      int     vm;
      int     ac;
      longint t;
      r  = $urandom_range(0, 7);
      t  = model_pos + longint'($urandom_range(0, 6000)) - 3000;
      vm = $urandom_range(20, 300);
      ac = $urandom_range(1, 40);
      if (r == 0) t = model_pos;
      if (r == 1) vm = 0;
      if (r == 2) ac = 0;
      issue(t, vm, ac, 0, 0, 0);
    end

    repeat (2 * D) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
